mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between three requesters:
  - CPU instruction fetch (if_)
  - CPU load/ldr data read (ld_)
  - external program loader / debug port (dl_), which may read or write
- Sits between the cpu top and the memory macro, replacing direct addr/rom_addr wiring.
- Serialises accesses with a fixed-priority plus round-robin policy and returns read data with per-requester valid pulses.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 37 +++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: FSM states and requester IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ID_IF = 2'd0,
        ID_LD = 2'd1,
        ID_DL = 2'd2
    } req_id_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: loader always wins, fetch/load alternate on ties.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       ld_req_i,
    input  logic       dl_req_i,
    input  req_id_e    rr_last_i,
    output logic [2:0] gnt_oh_o,
    output req_id_e    winner_o
);

    always_comb begin
        gnt_oh_o = 3'b000;
        winner_o = ID_IF;
        if (dl_req_i) begin
            gnt_oh_o = 3'b100;
            winner_o = ID_DL;
        end else if (if_req_i && ld_req_i) begin
            // Tie: whoever was not served last goes now.
            if (rr_last_i == ID_IF) begin
                gnt_oh_o = 3'b010;
                winner_o = ID_LD;
            end else begin
                gnt_oh_o = 3'b001;
                winner_o = ID_IF;
            end
        end else if (ld_req_i) begin
            gnt_oh_o = 3'b010;
            winner_o = ID_LD;
        end else if (if_req_i) begin
            gnt_oh_o = 3'b001;
            winner_o = ID_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, load and loader requesters.
// state | meaning: IDLE arbitrate | ISSUE mem access | WAIT read latency | RESP valid pulse
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ld_req,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    input  logic          dl_req,
    input  logic          dl_we,
    input  logic [AW-1:0] dl_addr,
    input  logic [DW-1:0] dl_wdata,
    output logic          dl_gnt,
    output logic          dl_done,
    output logic [DW-1:0] dl_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_e        state_q, state_d;
    req_id_e       owner_q, owner_d;
    req_id_e       rr_last_q, rr_last_d;
    logic          wr_q, wr_d;
    logic [2:0]    lat_cnt_q, lat_cnt_d;
    logic          if_gnt_q, if_gnt_d, ld_gnt_q, ld_gnt_d, dl_gnt_q, dl_gnt_d;
    logic          if_rvalid_q, if_rvalid_d, ld_rvalid_q, ld_rvalid_d, dl_done_q, dl_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, ld_rdata_q, ld_rdata_d, dl_rdata_q, dl_rdata_d;
    logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d, busy_q, busy_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    logic [2:0]    pick_oh;
    req_id_e       pick_id;

    arb_pick u_pick (
        .if_req_i  (if_req),
        .ld_req_i  (ld_req),
        .dl_req_i  (dl_req),
        .rr_last_i (rr_last_q),
        .gnt_oh_o  (pick_oh),
        .winner_o  (pick_id)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        wr_d        = wr_q;
        lat_cnt_d   = lat_cnt_q;
        if_rdata_d  = if_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        dl_rdata_d  = dl_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        ld_gnt_d    = 1'b0;
        dl_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ld_rvalid_d = 1'b0;
        dl_done_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || ld_req || dl_req) begin
                    state_d  = ISSUE;
                    owner_d  = pick_id;
                    wr_d     = (pick_id == ID_DL) && dl_we;
                    if_gnt_d = pick_oh[0];
                    ld_gnt_d = pick_oh[1];
                    dl_gnt_d = pick_oh[2];
                    mem_en_d = 1'b1;
                    mem_we_d = (pick_id == ID_DL) && dl_we;
                    case (pick_id)
                        ID_LD:   mem_addr_d = ld_addr;
                        ID_DL:   mem_addr_d = dl_addr;
                        default: mem_addr_d = if_addr;
                    endcase
                    if (pick_id == ID_DL) begin
                        mem_wdata_d = dl_wdata;
                    end else begin
                        rr_last_d = pick_id;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_d = 3'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q + 3'd1;
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = RESP;
                    case (owner_q)
                        ID_IF: begin
                            if_rdata_d  = mem_rdata;
                            if_rvalid_d = 1'b1;
                        end
                        ID_LD: begin
                            ld_rdata_d  = mem_rdata;
                            ld_rvalid_d = 1'b1;
                        end
                        default: begin
                            if (!wr_q) dl_rdata_d = mem_rdata;
                            dl_done_d = 1'b1;
                        end
                    endcase
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= ID_IF;
            rr_last_q   <= ID_IF;
            wr_q        <= 1'b0;
            lat_cnt_q   <= 3'd0;
            if_gnt_q    <= 1'b0;
            ld_gnt_q    <= 1'b0;
            dl_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ld_rvalid_q <= 1'b0;
            dl_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            ld_rdata_q  <= '0;
            dl_rdata_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            wr_q        <= wr_d;
            lat_cnt_q   <= lat_cnt_d;
            if_gnt_q    <= if_gnt_d;
            ld_gnt_q    <= ld_gnt_d;
            dl_gnt_q    <= dl_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ld_rvalid_q <= ld_rvalid_d;
            dl_done_q   <= dl_done_d;
            if_rdata_q  <= if_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            dl_rdata_q  <= dl_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ld_gnt    = ld_gnt_q;
    assign dl_gnt    = dl_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ld_rvalid = ld_rvalid_q;
    assign dl_done   = dl_done_q;
    assign if_rdata  = if_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign dl_rdata  = dl_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: one arbiter with 1-cycle memory, one with 3-cycle memory.
module tb_mem_arbiter;

    logic        clk, rst;
    logic        if_req, ld_req, dl_req, dl_we;
    logic [15:0] if_addr, ld_addr, dl_addr, dl_wdata;

    logic        if_gnt, if_rvalid, ld_gnt, ld_rvalid, dl_gnt, dl_done;
    logic        mem_en, mem_we, busy;
    logic [15:0] if_rdata, ld_rdata, dl_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        d3_if_gnt, d3_if_rvalid, d3_ld_gnt, d3_ld_rvalid, d3_dl_gnt, d3_dl_done;
    logic        d3_mem_en, d3_mem_we, d3_busy;
    logic [15:0] d3_if_rdata, d3_ld_rdata, d3_dl_rdata, d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .dl_req(dl_req), .dl_we(dl_we), .dl_addr(dl_addr), .dl_wdata(dl_wdata),
        .dl_gnt(dl_gnt), .dl_done(dl_done), .dl_rdata(dl_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(d3_if_gnt), .if_rvalid(d3_if_rvalid), .if_rdata(d3_if_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(d3_ld_gnt), .ld_rvalid(d3_ld_rvalid), .ld_rdata(d3_ld_rdata),
        .dl_req(dl_req), .dl_we(dl_we), .dl_addr(dl_addr), .dl_wdata(dl_wdata),
        .dl_gnt(d3_dl_gnt), .dl_done(d3_dl_done), .dl_rdata(d3_dl_rdata),
        .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_wdata(d3_mem_wdata),
        .mem_rdata(d3_mem_rdata), .busy(d3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations return a fixed pattern so reads need no preload.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0010) return 16'hA5A5;
        if (a == 16'h0008) return 16'h00FF;
        return a ^ 16'hC3C3;
    endfunction

    logic [15:0] mem1 [int];
    logic [15:0] mem3 [int];
    logic [15:0] pipe1;
    logic [15:0] pipe3 [3];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem1[int'(mem_addr)] = mem_wdata;
        if (d3_mem_en && d3_mem_we) mem3[int'(d3_mem_addr)] = d3_mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_en && !mem_we)
            pipe1 <= mem1.exists(int'(mem_addr)) ? mem1[int'(mem_addr)] : init_val(mem_addr);
        else
            pipe1 <= 16'hDEAD;
        if (d3_mem_en && !d3_mem_we)
            pipe3[0] <= mem3.exists(int'(d3_mem_addr)) ? mem3[int'(d3_mem_addr)] : init_val(d3_mem_addr);
        else
            pipe3[0] <= 16'hDEAD;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign mem_rdata    = pipe1;
    assign d3_mem_rdata = pipe3[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || d3_busy) && n < 20) begin
            tick();
            n++;
        end
        tick();
        vec_cnt++;
        if (busy !== 1'b0 || d3_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_idle: busy=%b d3_busy=%b expected 0 within 20 cycles", busy, d3_busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req = 0; ld_req = 0; dl_req = 0; dl_we = 0;
        if_addr = '0; ld_addr = '0; dl_addr = '0; dl_wdata = '0;
        tick(); tick();
        vec_cnt++;
        if ({if_gnt, ld_gnt, dl_gnt, if_rvalid, ld_rvalid, dl_done, mem_en, mem_we, busy} !== 9'b0) begin
            err_cnt++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {if_gnt, ld_gnt, dl_gnt, if_rvalid, ld_rvalid, dl_done, mem_en, mem_we, busy});
        end
        vec_cnt++;
        if ({mem_addr, mem_wdata, if_rdata, ld_rdata, dl_rdata} !== 80'b0) begin
            err_cnt++;
            $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, ld_rdata, dl_rdata});
        end
        rst = 1'b0;
        tick();
        vec_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        ld_req = 1; ld_addr = 16'h0008;
        tick();
        vec_cnt++;
        if ({ld_gnt, mem_en, mem_addr} !== {1'b1, 1'b1, 16'h0008}) begin
            err_cnt++;
            $display("FAIL midrst_gnt: got gnt=%b en=%b addr=%h expected 1 1 0008", ld_gnt, mem_en, mem_addr);
        end
        ld_req = 0;
        tick();
        rst = 1'b1;
        #1;
        vec_cnt++;
        if ({if_gnt, ld_gnt, dl_gnt, if_rvalid, ld_rvalid, dl_done, mem_en, mem_we, busy, mem_addr, ld_rdata} !== 41'b0) begin
            err_cnt++;
            $display("FAIL midrst_clear: busy=%b ld_rvalid=%b mem_addr=%h ld_rdata=%h expected all 0",
                     busy, ld_rvalid, mem_addr, ld_rdata);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            vec_cnt++;
            if ({ld_rvalid, busy} !== 2'b00) begin
                err_cnt++;
                $display("FAIL midrst_after c%0d: ld_rvalid=%b busy=%b expected 0 0", c, ld_rvalid, busy);
            end
        end
    endtask

    task automatic test_tie();
        int         gcyc [$];
        logic [1:0] gid  [$];
        int         rv = 0;
        int         exp_c [4] = '{1, 5, 9, 13};
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        if_req = 1; if_addr = 16'h0002;
        ld_req = 1; ld_addr = 16'h0100;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (if_gnt || ld_gnt) begin
                gcyc.push_back(c);
                gid.push_back({if_gnt, ld_gnt});
                if (gcyc.size() == 4) begin
                    if_req = 0;
                    ld_req = 0;
                end
            end
            if (ld_rvalid) begin
                rv++;
                vec_cnt++;
                if (ld_rdata !== 16'hC2C3) begin
                    err_cnt++;
                    $display("FAIL tie_ld_rdata c%0d: got %h expected c2c3", c, ld_rdata);
                end
            end
            if (if_rvalid) begin
                rv++;
                vec_cnt++;
                if (if_rdata !== 16'hC3C1) begin
                    err_cnt++;
                    $display("FAIL tie_if_rdata c%0d: got %h expected c3c1", c, if_rdata);
                end
            end
        end
        vec_cnt++;
        if (gcyc.size() !== 4 || rv !== 4) begin
            err_cnt++;
            $display("FAIL tie_counts: grants=%0d rvalids=%0d expected 4 4", gcyc.size(), rv);
        end
        for (int i = 0; i < gcyc.size() && i < 4; i++) begin
            vec_cnt++;
            if (gcyc[i] !== exp_c[i] || gid[i] !== exp_g[i]) begin
                err_cnt++;
                $display("FAIL tie_grant%0d: cycle=%0d {if,ld}=%b expected cycle=%0d {if,ld}=%b",
                         i, gcyc[i], gid[i], exp_c[i], exp_g[i]);
            end
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 16'h0010;
        tick();
        vec_cnt++;
        if ({if_gnt, ld_gnt, dl_gnt, mem_en, mem_we, busy, mem_addr} !== {6'b100101, 16'h0010}) begin
            err_cnt++;
            $display("FAIL fetch_c1: gnt=%b%b%b en=%b we=%b busy=%b addr=%h expected 100 1 0 1 0010",
                     if_gnt, ld_gnt, dl_gnt, mem_en, mem_we, busy, mem_addr);
        end
        if_req = 0;
        tick();
        vec_cnt++;
        if ({if_gnt, mem_en, if_rvalid, busy} !== 4'b0001) begin
            err_cnt++;
            $display("FAIL fetch_c2: gnt=%b en=%b rvalid=%b busy=%b expected 0 0 0 1", if_gnt, mem_en, if_rvalid, busy);
        end
        tick();
        vec_cnt++;
        if ({if_rvalid, busy, if_rdata} !== {2'b11, 16'hA5A5}) begin
            err_cnt++;
            $display("FAIL fetch_c3: rvalid=%b busy=%b rdata=%h expected 1 1 a5a5", if_rvalid, busy, if_rdata);
        end
        tick();
        vec_cnt++;
        if ({if_rvalid, busy, if_rdata} !== {2'b00, 16'hA5A5}) begin
            err_cnt++;
            $display("FAIL fetch_c4: rvalid=%b busy=%b rdata=%h expected 0 0 a5a5", if_rvalid, busy, if_rdata);
        end
    endtask

    task automatic test_loader_write();
        dl_req = 1; dl_we = 1; dl_addr = 16'h0040; dl_wdata = 16'h1234;
        if_req = 1; if_addr = 16'h0040;
        tick();
        vec_cnt++;
        if ({if_gnt, dl_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {4'b0111, 16'h0040, 16'h1234}) begin
            err_cnt++;
            $display("FAIL dl_c1: if_gnt=%b dl_gnt=%b en=%b we=%b addr=%h wdata=%h expected 0 1 1 1 0040 1234",
                     if_gnt, dl_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        dl_req = 0; dl_we = 0;
        tick();
        vec_cnt++;
        if ({dl_gnt, mem_en, mem_we, dl_done} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL dl_c2: gnt=%b en=%b we=%b done=%b expected 0", dl_gnt, mem_en, mem_we, dl_done);
        end
        tick();
        vec_cnt++;
        if ({dl_done, if_gnt, mem_en} !== 3'b100) begin
            err_cnt++;
            $display("FAIL dl_c3: done=%b if_gnt=%b en=%b expected 1 0 0", dl_done, if_gnt, mem_en);
        end
        tick();
        vec_cnt++;
        if ({dl_done, if_gnt, busy} !== 3'b000) begin
            err_cnt++;
            $display("FAIL dl_c4: done=%b if_gnt=%b busy=%b expected 0 0 0", dl_done, if_gnt, busy);
        end
        tick();
        vec_cnt++;
        if ({if_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 16'h0040}) begin
            err_cnt++;
            $display("FAIL dl_fetch_gnt: gnt=%b en=%b we=%b addr=%h expected 1 1 0 0040", if_gnt, mem_en, mem_we, mem_addr);
        end
        if_req = 0;
        tick(); tick();
        vec_cnt++;
        if ({if_rvalid, if_rdata} !== {1'b1, 16'h1234}) begin
            err_cnt++;
            $display("FAIL dl_readback: rvalid=%b rdata=%h expected 1 1234", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_dropped();
        if_req = 1; if_addr = 16'h0010;
        tick();
        if_req = 0;
        ld_req = 1; ld_addr = 16'h0077;
        tick();
        ld_req = 0;
        for (int c = 2; c <= 8; c++) begin
            vec_cnt++;
            if ({ld_gnt, ld_rvalid, (mem_en && mem_addr == 16'h0077)} !== 3'b000) begin
                err_cnt++;
                $display("FAIL drop_c%0d: ld_gnt=%b ld_rvalid=%b en=%b addr=%h expected no ld access",
                         c, ld_gnt, ld_rvalid, mem_en, mem_addr);
            end
            if (c == 3) begin
                vec_cnt++;
                if ({if_rvalid, if_rdata} !== {1'b1, 16'hA5A5}) begin
                    err_cnt++;
                    $display("FAIL drop_fetch: rvalid=%b rdata=%h expected 1 a5a5", if_rvalid, if_rdata);
                end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        ld_req = 1; ld_addr = 16'h0008;
        tick();
        vec_cnt++;
        if ({d3_ld_gnt, d3_mem_en, d3_mem_addr} !== {2'b11, 16'h0008}) begin
            err_cnt++;
            $display("FAIL lat3_gnt: gnt=%b en=%b addr=%h expected 1 1 0008", d3_ld_gnt, d3_mem_en, d3_mem_addr);
        end
        ld_req = 0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            vec_cnt++;
            if (d3_ld_rvalid !== (c == 5)) begin
                err_cnt++;
                $display("FAIL lat3_rvalid_c%0d: got %b expected %b", c, d3_ld_rvalid, (c == 5));
            end
            if (c == 5) begin
                vec_cnt++;
                if (d3_ld_rdata !== 16'h00FF) begin
                    err_cnt++;
                    $display("FAIL lat3_rdata: got %h expected 00ff", d3_ld_rdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_tie();
        wait_idle();
        test_single_fetch();
        wait_idle();
        test_loader_write();
        wait_idle();
        test_dropped();
        wait_idle();
        test_latency();
        wait_idle();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
